// File: rtl/irq_arbiter_pkg.sv
// ============================================================================
// irq_arbiter_pkg : register map, FSM encoding and constants for irq_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package irq_arbiter_pkg;

   localparam logic [1:0]  REG_MASK = 2'd0;
   localparam logic [1:0]  REG_PEND = 2'd1;
   localparam logic [1:0]  REG_ID   = 2'd2;
   localparam logic [1:0]  REG_CTRL = 2'd3;

   localparam int          CTRL_EN_BIT      = 0;
   localparam int          ID_W             = 3;
   localparam logic [31:0] INT_CLR_ADDR_DEF = 32'h0000_7F20;
   localparam logic [3:0]  INT_CLR_BYTEEN   = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/irq_arbiter_prio_sel.sv
// ============================================================================
// irq_prio_sel : picks one eligible source; lowest index, or round-robin
// after the last grant when IRQ_ARB_RR_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module irq_prio_sel
   import irq_arbiter_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0] eligible_i,
`ifdef IRQ_ARB_RR_EN
   input  logic [ID_W-1:0] ptr_i,
`endif
   output logic            valid_o,
   output logic [ID_W-1:0] index_o
);

   assign valid_o = |eligible_i;

`ifdef IRQ_ARB_RR_EN
   logic [ID_W-1:0]   start_w;
   logic [2*NSRC-1:0] dbl_w;
   logic [NSRC-1:0]   rot_w;

   assign start_w = (ptr_i >= ID_W'(NSRC-1)) ? '0 : ptr_i + ID_W'(1);
   assign dbl_w   = {eligible_i, eligible_i};
   // rot_w[k] corresponds to source (start_w + k) mod NSRC
   assign rot_w   = NSRC'(dbl_w >> start_w);

   always_comb begin
      int s;
      s       = 0;
      index_o = '0;
      for (int k = NSRC-1; k >= 0; k--) begin
         if (rot_w[k]) begin
            s = int'(start_w) + k;
            if (s >= NSRC) s = s - NSRC;
            index_o = ID_W'(s);
         end
      end
   end
`else
   always_comb begin
      index_o = '0;
      for (int k = NSRC-1; k >= 0; k--) begin
         if (eligible_i[k]) index_o = ID_W'(k);
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ============================================================================
// irq_arbiter : edge-latched, masked interrupt arbiter with CPU handshake,
// generator clear strobe and EOI.  Optional macro: IRQ_ARB_RR_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int          NSRC         = 4,
   parameter int          EXT_ID       = 2,
   parameter logic [31:0] INT_CLR_ADDR = INT_CLR_ADDR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            irq_out,
   output logic [2:0]      irq_id,
   input  logic            ack,
   output logic            int_clr_we,
   output logic [31:0]     int_clr_addr,
   output logic [3:0]      int_clr_byteen
);

   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic            en_q, en_d;
   state_e          state_q, state_d;
   logic [ID_W-1:0] cur_id_q, cur_id_d;
   logic            irq_out_q;
   logic            clr_we_q, clr_we_d;
   logic            ack_clr_d;

   logic [NSRC-1:0] edge_w, elig_w, cur_oh_w, w1c_w, ackmask_w;
   logic            cur_elig_w, sel_valid_w;
   logic [ID_W-1:0] sel_idx_w;
   logic            wr_mask_w, wr_pend_w, wr_id_w, wr_ctrl_w;
   logic            unused_wdata;

   assign unused_wdata = ^wdata[31:NSRC];

   assign wr_mask_w = we && (addr == REG_MASK);
   assign wr_pend_w = we && (addr == REG_PEND);
   assign wr_id_w   = we && (addr == REG_ID);
   assign wr_ctrl_w = we && (addr == REG_CTRL);

   assign edge_w     = irq_src & ~src_q;
   assign elig_w     = en_q ? (pend_q & mask_q) : '0;
   assign cur_oh_w   = NSRC'(1) << cur_id_q;
   assign cur_elig_w = |(elig_w & cur_oh_w);

`ifdef IRQ_ARB_RR_EN
   logic [ID_W-1:0] ptr_q;

   always_ff @(posedge clk) begin
      if (!reset)         ptr_q <= '0;
      else if (ack_clr_d) ptr_q <= cur_id_q;
   end

   irq_prio_sel #(.NSRC(NSRC)) u_sel (
      .eligible_i (elig_w),
      .ptr_i      (ptr_q),
      .valid_o    (sel_valid_w),
      .index_o    (sel_idx_w)
   );
`else
   irq_prio_sel #(.NSRC(NSRC)) u_sel (
      .eligible_i (elig_w),
      .valid_o    (sel_valid_w),
      .index_o    (sel_idx_w)
   );
`endif

   always_comb begin
      state_d   = state_q;
      cur_id_d  = cur_id_q;
      ack_clr_d = 1'b0;
      clr_we_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid_w) begin
               cur_id_d = sel_idx_w;
               state_d  = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            // The handshake wins over a withdrawal arriving in the same cycle
            if (ack) begin
               state_d   = ST_SERVICE;
               ack_clr_d = 1'b1;
               clr_we_d  = (cur_id_q == ID_W'(EXT_ID));
            end else if (!cur_elig_w) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (wr_id_w) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign w1c_w     = wr_pend_w ? wdata[NSRC-1:0] : '0;
   assign ackmask_w = ack_clr_d ? cur_oh_w : '0;
   // New edges are OR'ed in last so they survive a same-cycle clear
   assign pend_d    = (pend_q & ~w1c_w & ~ackmask_w) | edge_w;
   assign mask_d    = wr_mask_w ? wdata[NSRC-1:0] : mask_q;
   assign en_d      = wr_ctrl_w ? wdata[CTRL_EN_BIT] : en_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         src_q     <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         en_q      <= 1'b0;
         state_q   <= ST_IDLE;
         cur_id_q  <= '0;
         irq_out_q <= 1'b0;
         clr_we_q  <= 1'b0;
      end else begin
         src_q     <= irq_src;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         en_q      <= en_d;
         state_q   <= state_d;
         cur_id_q  <= cur_id_d;
         irq_out_q <= (state_d == ST_ASSERT);
         clr_we_q  <= clr_we_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         REG_MASK: rdata = 32'(mask_q);
         REG_PEND: rdata = 32'(pend_q);
         REG_ID:   rdata = {27'b0, state_q, cur_id_q};
         REG_CTRL: rdata = {31'b0, en_q};
         default:  rdata = '0;
      endcase
   end

   assign irq_out        = irq_out_q;
   assign irq_id         = cur_id_q;
   assign int_clr_we     = clr_we_q;
   assign int_clr_addr   = clr_we_q ? INT_CLR_ADDR : '0;
   assign int_clr_byteen = clr_we_q ? INT_CLR_BYTEEN : '0;

endmodule

`default_nettype wire
